// File: rtl/hilo_acc.sv
// hilo_acc: HI/LO register pair with an optional two-cycle multiply-style
// accumulate path. The pair {hi_o,lo_o} forms one 2*DATA_W value.
//
// Write commands (WHI, WLO, WBOTH) update their register(s) on the edge
// where they are accepted. MADD/MSUB take two edges. The first edge updates
// LO and saves the carry or borrow. The second edge folds that carry or
// borrow into HI.
//
// Build option: define HILO_ACC_MAC_EN to include the accumulate datapath.
// Without it, MADD/MSUB decode as NOP and the block is always ready.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous, active-high reset
//   valid_i  in   command valid
//   op_i     in   command code (000 NOP, 001 WHI, 010 WLO, 011 WBOTH,
//                 100 MADD, 101 MSUB, 110/111 NOP)
//   hi_i     in   HI operand / upper half of accumulate operand
//   lo_i     in   LO operand / lower half of accumulate operand
//   ready_o  out  command accepted on an edge where valid_i && ready_o
//   busy_o   out  accumulate in progress (ACC_HI)
//   hi_o     out  registered HI value
//   lo_o     out  registered LO value
//
// state  | meaning
// IDLE   | accepting commands; writes complete here in one edge
// ACC_HI | second half of MADD/MSUB: HI += / -= hi_cap with carry/borrow
module hilo_acc #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [2:0] OP_WHI   = 3'b001;
  localparam logic [2:0] OP_WLO   = 3'b010;
  localparam logic [2:0] OP_WBOTH = 3'b011;

  logic [DATA_W-1:0] hi_d;
  logic [DATA_W-1:0] lo_d;
  logic              accept;

`ifdef HILO_ACC_MAC_EN
  localparam logic [2:0] OP_MADD = 3'b100;
  localparam logic [2:0] OP_MSUB = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    ACC_HI = 1'b1
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [DATA_W-1:0] hi_cap;
  logic [DATA_W-1:0] hi_cap_d;
  logic              carry;   // carry for MADD, borrow for MSUB
  logic              carry_d;
  logic              sub;     // remembers which accumulate is in flight
  logic              sub_d;
  logic [DATA_W:0]   lo_sum;
  logic [DATA_W:0]   lo_diff;
  logic [DATA_W-1:0] cin_ext;

  // Both outputs decode only the state register. Inputs do not reach them
  // through any combinational path.
  assign ready_o = (state == IDLE);
  assign busy_o  = (state == ACC_HI);
  assign accept  = valid_i & ready_o;

  // One extra bit holds the carry-out. For the difference, that top bit is
  // set exactly when lo_o < lo_i, which is the borrow.
  assign lo_sum  = {1'b0, lo_o} + {1'b0, lo_i};
  assign lo_diff = {1'b0, lo_o} - {1'b0, lo_i};
  assign cin_ext = {{(DATA_W-1){1'b0}}, carry};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      hi_o   <= '0;
      lo_o   <= '0;
      hi_cap <= '0;
      carry  <= 1'b0;
      sub    <= 1'b0;
    end else begin
      state  <= state_d;
      hi_o   <= hi_d;
      lo_o   <= lo_d;
      hi_cap <= hi_cap_d;
      carry  <= carry_d;
      sub    <= sub_d;
    end
  end

  always_comb begin
    state_d  = state;
    hi_d     = hi_o;
    lo_d     = lo_o;
    hi_cap_d = hi_cap;
    carry_d  = carry;
    sub_d    = sub;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op_i)
            OP_WHI:   hi_d = hi_i;
            OP_WLO:   lo_d = lo_i;
            OP_WBOTH: begin
              hi_d = hi_i;
              lo_d = lo_i;
            end
            OP_MADD: begin
              lo_d     = lo_sum[DATA_W-1:0];
              carry_d  = lo_sum[DATA_W];
              hi_cap_d = hi_i;
              sub_d    = 1'b0;
              state_d  = ACC_HI;
            end
            OP_MSUB: begin
              lo_d     = lo_diff[DATA_W-1:0];
              carry_d  = lo_diff[DATA_W];
              hi_cap_d = hi_i;
              sub_d    = 1'b1;
              state_d  = ACC_HI;
            end
            default: ;
          endcase
        end
      end
      ACC_HI: begin
        // Completes whatever valid_i does; the source is stalled by ready_o.
        if (sub) hi_d = hi_o - hi_cap - cin_ext;
        else     hi_d = hi_o + hi_cap + cin_ext;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`else
  // No accumulate path, so the block never stalls.
  assign ready_o = 1'b1;
  assign busy_o  = 1'b0;
  assign accept  = valid_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else begin
      hi_o <= hi_d;
      lo_o <= lo_d;
    end
  end

  always_comb begin
    hi_d = hi_o;
    lo_d = lo_o;
    if (accept) begin
      case (op_i)
        OP_WHI:   hi_d = hi_i;
        OP_WLO:   lo_d = lo_i;
        OP_WBOTH: begin
          hi_d = hi_i;
          lo_d = lo_i;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_hilo_acc.sv
// tb_hilo_acc: directed and random checks of hilo_acc.
// The reference is one 64-bit accumulator value, updated with plain 64-bit
// arithmetic. The same bench covers both builds (with and without
// HILO_ACC_MAC_EN).
module tb_hilo_acc;

`ifdef HILO_ACC_MAC_EN
  localparam bit MAC_EN = 1'b1;
`else
  localparam bit MAC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] hi_i = '0;
  logic [31:0] lo_i = '0;
  logic        ready_o;
  logic        busy_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] acc;   // reference {hi,lo}

  hilo_acc #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i),
    .hi_i(hi_i), .lo_i(lo_i), .ready_o(ready_o), .busy_o(busy_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference effect of one accepted command on {hi,lo}.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [2:0] op,
                                        input logic [31:0] h, input logic [31:0] l);
    logic [63:0] r;
    r = a;
    case (op)
      3'd1: r[63:32] = h;
      3'd2: r[31:0]  = l;
      3'd3: r = {h, l};
      3'd4: if (MAC_EN) r = a + {h, l};
      3'd5: if (MAC_EN) r = a - {h, l};
      default: ;
    endcase
    return r;
  endfunction

  // Issue one command with valid high and check every edge until it
  // completes. The block is then back in IDLE.
  task automatic do_cmd(input string tag, input logic [2:0] op,
                        input logic [31:0] h, input logic [31:0] l);
    logic [63:0] old;
    old = acc;
    valid_i = 1'b1; op_i = op; hi_i = h; lo_i = l;
    step();
    valid_i = 1'b0;
    acc = model(old, op, h, l);
    if (MAC_EN && (op == 3'd4 || op == 3'd5)) begin
      chk({tag, ".mid_lo"},    {32'd0, lo_o}, {32'd0, acc[31:0]});
      chk({tag, ".mid_hi"},    {32'd0, hi_o}, {32'd0, old[63:32]});
      chk({tag, ".mid_busy"},  {63'd0, busy_o},  64'd1);
      chk({tag, ".mid_ready"}, {63'd0, ready_o}, 64'd0);
      step();
    end
    chk({tag, ".hilo"},  {hi_o, lo_o}, acc);
    chk({tag, ".busy"},  {63'd0, busy_o},  64'd0);
    chk({tag, ".ready"}, {63'd0, ready_o}, 64'd1);
  endtask

  initial begin
    acc = '0;
    // Reset state
    #2;
    chk("rst.hilo",  {hi_o, lo_o}, 64'd0);
    chk("rst.ready", {63'd0, ready_o}, 64'd1);
    chk("rst.busy",  {63'd0, busy_o},  64'd0);
    step();
    rst = 1'b0;

    // Single-register writes leave the other register alone
    do_cmd("whi", 3'd1, 32'h1234_5678, 32'hDEAD_BEEF);
    do_cmd("wlo", 3'd2, 32'hCAFE_F00D, 32'h9ABC_DEF0);

    // Carry from LO into HI
    do_cmd("wb1", 3'd3, 32'h0000_0001, 32'hFFFF_FFFF);
    do_cmd("madd_carry", 3'd4, 32'h0, 32'h1);

    // 2^64 wrap on subtract
    do_cmd("wb0", 3'd3, 32'h0, 32'h0);
    do_cmd("msub_wrap", 3'd5, 32'h0, 32'h1);
    do_cmd("madd_b2b", 3'd4, 32'h0, 32'h1);
    do_cmd("msub_b2b", 3'd5, 32'h7, 32'h8000_0000);

    // Undefined codes and NOP change nothing
    do_cmd("nop", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_cmd("op6", 3'd6, 32'h1111_1111, 32'h2222_2222);
    do_cmd("op7", 3'd7, 32'h3333_3333, 32'h4444_4444);

    // WBOTH held during ACC_HI is ignored, then taken in IDLE
    do_cmd("wb5", 3'd3, 32'h0000_0010, 32'h0000_0005);
    valid_i = 1'b1; op_i = 3'd4; hi_i = 32'h5; lo_i = 32'h5;
    step();
    acc = model(acc, 3'd4, 32'h5, 32'h5);
    op_i = 3'd3; hi_i = 32'hAAAA_AAAA; lo_i = 32'h5555_5555;
    step();
    if (!MAC_EN) acc = model(acc, 3'd3, 32'hAAAA_AAAA, 32'h5555_5555);
    chk("hold.acc_done", {hi_o, lo_o}, acc);
    chk("hold.ready", {63'd0, ready_o}, 64'd1);
    step();
    valid_i = 1'b0;
    acc = model(acc, 3'd3, 32'hAAAA_AAAA, 32'h5555_5555);
    chk("hold.wboth", {hi_o, lo_o}, acc);

    // Asynchronous reset during an accumulate
    do_cmd("wbr", 3'd3, 32'h0000_0100, 32'hFFFF_FFF0);
    valid_i = 1'b1; op_i = 3'd4; hi_i = 32'h1; lo_i = 32'h20;
    step();
    valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst.hilo",  {hi_o, lo_o}, 64'd0);
    chk("arst.ready", {63'd0, ready_o}, 64'd1);
    chk("arst.busy",  {63'd0, busy_o},  64'd0);
    acc = '0;
    #1 rst = 1'b0;
    do_cmd("post_rst", 3'd1, 32'h0BAD_CAFE, 32'h0);
    chk("post_rst.lo", {32'd0, lo_o}, 64'd0);

    // Random commands, with some idle cycles where valid_i is low
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        valid_i = 1'b0; op_i = 3'($urandom_range(0, 7));
        hi_i = $urandom; lo_i = $urandom;
        step();
        chk("rnd.idle", {hi_o, lo_o}, acc);
      end else begin
        do_cmd("rnd", 3'($urandom_range(0, 7)), $urandom, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
